// File: rtl/overcooked_tile_pkg.sv
// overcooked_tile_pkg
// Shared grid geometry for the kitchen tile map. The pixel-to-tile and
// tile-to-pixel blocks both import this package, so the two mappings
// always agree on layout.
//   - grid constants: COLS, ROWS, NUM_TILES, TILE_PX, X_ORIGIN, Y_ORIGIN
//   - widths: IDX_W (tile index / row / col), COORD_W (pixel coordinate)
//   - state_t: handshake FSM states of tile_index_to_coords
//   - tile_edge(): pixel position of a tile's leading edge along one axis
package overcooked_tile_pkg;

  localparam int COLS      = 15;
  localparam int ROWS      = 8;
  localparam int NUM_TILES = COLS * ROWS;
  localparam int TILE_PX   = 40;
  localparam int X_ORIGIN  = 20;
  localparam int Y_ORIGIN  = 100;

  localparam int IDX_W   = 7;
  localparam int COORD_W = 10;

  // Sized copies so that comparisons and arithmetic stay width-exact.
  localparam logic [IDX_W-1:0]   COLS_I      = IDX_W'(COLS);
  localparam logic [IDX_W-1:0]   NUM_TILES_I = IDX_W'(NUM_TILES);
  localparam logic [COORD_W-1:0] HALF_TILE   = COORD_W'(TILE_PX / 2);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } state_t;

  // origin + n * TILE_PX, truncated to the coordinate width. With the default
  // grid the largest result is 580, so nothing is lost to truncation.
  function automatic logic [COORD_W-1:0] tile_edge(input logic [IDX_W-1:0] n,
                                                   input int origin);
    return COORD_W'(origin) + COORD_W'(n) * COORD_W'(TILE_PX);
  endfunction

endpackage

// File: rtl/tile_row_divider.sv
// tile_row_divider
// Iterative divide-by-COLS for a tile index. A start pulse loads the index
// into the remainder register and clears the row count; each following cycle
// subtracts COLS once while the remainder is still >= COLS. When the
// remainder drops below COLS, done is high for exactly that cycle: row holds
// the quotient and rem holds the column.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      load dividend and begin (ignored bits: none)
//   dividend   tile index to split, must be < NUM_TILES
//   rem        current remainder (column once done)
//   row        current quotient (row once done)
//   done       result valid this cycle
module tile_row_divider
  import overcooked_tile_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] dividend,
  output logic [IDX_W-1:0] rem,
  output logic [IDX_W-1:0] row,
  output logic             done
);

  logic [IDX_W-1:0] rem_reg;
  logic [IDX_W-1:0] row_reg;
  logic             busy_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_reg  <= '0;
      row_reg  <= '0;
      busy_reg <= 1'b0;
    end else if (start) begin
      rem_reg  <= dividend;
      row_reg  <= '0;
      busy_reg <= 1'b1;
    end else if (busy_reg) begin
      if (rem_reg >= COLS_I) begin
        rem_reg <= rem_reg - COLS_I;
        row_reg <= row_reg + 1'b1;
      end else begin
        // Result is consumed by the caller on this same edge.
        busy_reg <= 1'b0;
      end
    end
  end

  assign rem  = rem_reg;
  assign row  = row_reg;
  assign done = busy_reg && (rem_reg < COLS_I);

endmodule

// File: rtl/tile_index_to_coords.sv
// tile_index_to_coords
// Converts a row-major kitchen tile index into row, column, top-left pixel
// corner and centre pixel. Row/column come from tile_row_divider (one
// subtraction per cycle, no divider); this level runs the request/response
// handshake and the coordinate multiply/offset.
// Ports:
//   Clk, Reset              clock, asynchronous active-high reset
//   in_valid / in_ready     request handshake; in_ready high only in IDLE
//   tileIndex               requested tile, sampled on accept
//   out_valid / out_ready   result handshake; result held until consumed
//   rowIndex, colIndex      tile row and column
//   xCoordinate, yCoordinate top-left pixel of the tile
//   xCentre, yCentre        centre pixel of the tile
//   out_err                 requested index was outside the grid
module tile_index_to_coords
  import overcooked_tile_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IDX_W-1:0]   tileIndex,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   rowIndex,
  output logic [IDX_W-1:0]   colIndex,
  output logic [COORD_W-1:0] xCoordinate,
  output logic [COORD_W-1:0] yCoordinate,
  output logic [COORD_W-1:0] xCentre,
  output logic [COORD_W-1:0] yCentre,
  output logic               out_err
);

  state_t           state_reg;
  logic             err_pending_reg;
  logic             accept;
  logic             in_range;
  logic             div_start;
  logic [IDX_W-1:0] div_rem;
  logic [IDX_W-1:0] div_row;
  logic             div_done;

  logic [COORD_W-1:0] x_next;
  logic [COORD_W-1:0] y_next;

  assign in_ready  = (state_reg == IDLE);
  assign accept    = in_valid && in_ready;
  assign in_range  = (tileIndex < NUM_TILES_I);
  assign div_start = accept && in_range;

  tile_row_divider u_divider (
    .clk      (Clk),
    .rst      (Reset),
    .start    (div_start),
    .dividend (tileIndex),
    .rem      (div_rem),
    .row      (div_row),
    .done     (div_done)
  );

  assign x_next = tile_edge(div_rem, X_ORIGIN);
  assign y_next = tile_edge(div_row, Y_ORIGIN);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg       <= IDLE;
      err_pending_reg <= 1'b0;
      out_valid       <= 1'b0;
      out_err         <= 1'b0;
      rowIndex        <= '0;
      colIndex        <= '0;
      xCoordinate     <= '0;
      yCoordinate     <= '0;
      xCentre         <= '0;
      yCentre         <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            // Out-of-range requests also pass through DIVIDE for one cycle
            // so that every result appears at least one edge after accept.
            err_pending_reg <= !in_range;
            state_reg       <= DIVIDE;
          end
        end

        DIVIDE: begin
          if (err_pending_reg) begin
            err_pending_reg <= 1'b0;
            out_err         <= 1'b1;
            out_valid       <= 1'b1;
            rowIndex        <= '0;
            colIndex        <= '0;
            xCoordinate     <= '0;
            yCoordinate     <= '0;
            xCentre         <= '0;
            yCentre         <= '0;
            state_reg       <= DONE;
          end else if (div_done) begin
            out_valid   <= 1'b1;
            rowIndex    <= div_row;
            colIndex    <= div_rem;
            xCoordinate <= x_next;
            yCoordinate <= y_next;
            xCentre     <= x_next + HALF_TILE;
            yCentre     <= y_next + HALF_TILE;
            state_reg   <= DONE;
          end
        end

        DONE: begin
          // Data outputs intentionally keep their value after consumption.
          if (out_ready) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tile_index_to_coords.md
Name: tile_index_to_coords

Overview:
Sequential inverse of the pixel-to-tile mapping. It takes a kitchen-grid tile index (row-major, 15 columns) and returns the tile's row, column, top-left pixel corner and centre pixel. Sprite placement and drop logic use it to snap chef-held items and station sprites onto tile positions. It uses no hardware divider: row and column come from iterative subtraction, and the block runs behind a valid/ready handshake on both sides.

Parameters:
COLS, 15, tiles per grid row
ROWS, 8, grid rows; NUM_TILES = COLS*ROWS = 120
TILE_PX, 40, tile edge length in pixels
X_ORIGIN, 20, pixel x of column 0 left edge
Y_ORIGIN, 100, pixel y of row 0 top edge

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
in_valid  in  1  request present
in_ready  out  1  block can accept a request
tileIndex  in  7  requested tile index, sampled on accept
out_valid  out  1  result valid, held until consumed
out_ready  in  1  consumer takes the result
rowIndex  out  7  tile row
colIndex  out  7  tile column
xCoordinate  out  10  top-left x = X_ORIGIN + col*TILE_PX
yCoordinate  out  10  top-left y = Y_ORIGIN + row*TILE_PX
xCentre  out  10  xCoordinate + TILE_PX/2
yCentre  out  10  yCoordinate + TILE_PX/2
out_err  out  1  requested index >= NUM_TILES

Behaviour:
- Reset state
  - Async reset forces state IDLE.
  - All registered outputs are 0: out_valid, out_err, row, col and all coordinates.
  - in_ready = 1 while in IDLE, including during reset.
- States: IDLE, DIVIDE, DONE.
- in_ready = (state == IDLE). It is combinational.
- Accept occurs on in_valid && in_ready at a rising edge.
  - tileIndex < NUM_TILES: latch rem = tileIndex, row = 0, go to DIVIDE.
  - tileIndex >= NUM_TILES: go to DONE with out_err = 1. Row, col and all coordinates are 0. out_valid rises 1 edge after accept.
- DIVIDE, once per cycle:
  - If rem >= COLS: rem -= COLS, row += 1.
  - Otherwise: col = rem, compute all coordinates, register them, set out_valid = 1, go to DONE.
- Latency: out_valid rises (row + 1) edges after the accepting edge. Index 0 takes 1 edge; index 119 takes 8 edges (maximum).
- Coordinate arithmetic
  - 10-bit unsigned; multiplication by a parameter constant is allowed.
  - For the default parameters, the maximum values are x = 580, y = 380, xCentre = 600, yCentre = 400. There is no overflow.
- DONE
  - All outputs are held stable while out_ready = 0.
  - On out_valid && out_ready: clear out_valid and out_err, go to IDLE.
  - Data outputs keep their last value after consumption.
  - One result per request. The minimum request-to-request interval is row + 3 cycles.
- in_valid outside IDLE is ignored. The requester must hold in_valid and tileIndex until in_ready.
- out_ready asserted while out_valid = 0 has no effect.
- Reset during DIVIDE or DONE discards the request immediately. No partial result is emitted.

Decomposition:
- Package overcooked_tile_pkg holds:
  - grid constants COLS, ROWS, NUM_TILES, TILE_PX, X_ORIGIN, Y_ORIGIN;
  - the state enum (IDLE, DIVIDE, DONE);
  - the tile index width (7) and coordinate width (10).
- coordsToTileIndex imports the same package constants.
- One sub-module is natural: tile_row_divider. It holds the iterative subtract-by-COLS datapath (rem/row registers, done flag).
- The top level holds the handshake FSM and the coordinate multiply/offset.

Test Plan:
1. Reset, then tileIndex = 0 with out_ready = 1 -> out_valid 1 edge after accept; row 0, col 0, x 20, y 100, xCentre 40, yCentre 120, err 0.
2. tileIndex = 16 -> out_valid after 2 edges; row 1, col 1, x 60, y 140, xCentre 80, yCentre 160.
3. tileIndex = 119 -> out_valid after 8 edges; row 7, col 14, x 580, y 380, xCentre 600, yCentre 400.
4. tileIndex = 120 and tileIndex = 127 -> out_valid after 1 edge; out_err 1; row, col and all coordinates 0.
5. tileIndex = 44 with out_ready held 0 for 5 cycles -> outputs stable (row 2, col 14, x 580, y 180), in_ready 0, and a competing in_valid with tileIndex = 3 is ignored. After out_ready = 1, the block returns to IDLE and the next request 3 yields x 140, y 100.
6. Accept tileIndex = 100, assert Reset asynchronously mid-DIVIDE -> outputs 0 immediately, in_ready 1. After release, tileIndex = 5 yields x 220, y 100 with latency 1 edge.
